// File: rtl/sbox_share_ctrl_if.sv
// Request/response bundle for sbox_share_ctrl: two requester channels (KS, DP)
// and the tagged result channel. The controller attaches through the slave modport.
interface sbox_share_ctrl_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    // Every channel transfers on a rising edge where valid && ready are both high.
    // Senders hold valid and payload stable until that edge; ready may depend
    // combinationally on valid.
    logic         ks_valid;
    logic         ks_ready;
    logic [W-1:0] ks_data;
    logic         dp_valid;
    logic         dp_ready;
    logic [W-1:0] dp_data;
    logic         dp_inverse;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_owner;

    modport slave (
        input  ks_valid, ks_data, dp_valid, dp_data, dp_inverse, rsp_ready,
        output ks_ready, dp_ready, rsp_valid, rsp_data, rsp_owner
    );

    modport master (
        output ks_valid, ks_data, dp_valid, dp_data, dp_inverse, rsp_ready,
        input  ks_ready, dp_ready, rsp_valid, rsp_data, rsp_owner
    );
endinterface

// File: rtl/sbox_share_ctrl.sv
// Round-robin time-sharing of one combined forward/inverse AES S-box between KS and DP.
// Optional macro SBOX_SHARE_OUT_REG_EN adds a pipeline register on the S-box output.
module sbox_share_ctrl #(
    parameter int NBYTES  = 4,
    parameter bit RR_INIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sbox_share_ctrl_if.slave     bus,
    output logic                 busy,
    output logic [1:0]           state_dbg
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES + 1);
`ifdef SBOX_SHARE_OUT_REG_EN
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES);
`else
    localparam logic [CW-1:0] LAST_CNT = CW'(NBYTES - 1);
`endif

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  word_q, word_d;
    logic [W-1:0]  result_q, result_d;
    logic          inv_q, inv_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          grant_dp;
    logic [W-1:0]  word_shift;
    logic [7:0]    sbox_in, sbox_out, wr_byte;
    logic [CW-1:0] wr_idx;
    logic          wr_en;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq, r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] b;
        if (inv) begin
            b = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
            return gf_inv(b);
        end
        b = gf_inv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    assign word_shift = word_q >> {cnt_q, 3'b000};
    assign sbox_in    = word_shift[7:0];
    assign sbox_out   = sbox(sbox_in, inv_q);

`ifdef SBOX_SHARE_OUT_REG_EN
    logic [7:0] sbox_reg_q, sbox_reg_d;
    // Captures only real bytes; the extra drain cycle and DONE/IDLE leave it at zero.
    assign sbox_reg_d = (state_q == BUSY && cnt_q != CW'(NBYTES)) ? sbox_out : 8'h00;
    assign wr_byte    = sbox_reg_q;
    assign wr_idx     = cnt_q - CW'(1);
    assign wr_en      = (state_q == BUSY) && (cnt_q != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sbox_reg_q <= 8'h00;
        else        sbox_reg_q <= sbox_reg_d;
    end
`else
    assign wr_byte = sbox_out;
    assign wr_idx  = cnt_q;
    assign wr_en   = (state_q == BUSY);
`endif

    // On contention the requester that did not win last time gets the grant.
    assign grant_dp = bus.dp_valid && (!bus.ks_valid || !last_owner_q);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        result_d     = result_q;
        inv_d        = inv_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        bus.ks_ready  = 1'b0;
        bus.dp_ready  = 1'b0;
        bus.rsp_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ks_valid || bus.dp_valid) begin
                    bus.dp_ready = grant_dp;
                    bus.ks_ready = !grant_dp;
                    word_d       = grant_dp ? bus.dp_data : bus.ks_data;
                    inv_d        = grant_dp && bus.dp_inverse;
                    owner_d      = grant_dp;
                    last_owner_d = grant_dp;
                    cnt_d        = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (wr_en) begin
                    for (int k = 0; k < NBYTES; k++) begin
                        if (wr_idx == CW'(k)) result_d[8*k +: 8] = wr_byte;
                    end
                end
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            result_q     <= '0;
            inv_q        <= 1'b0;
            owner_q      <= 1'b0;
            last_owner_q <= ~RR_INIT;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            result_q     <= result_d;
            inv_q        <= inv_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.rsp_data  = result_q;
    assign bus.rsp_owner = owner_q;
    assign busy          = (state_q != IDLE);
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Scoreboard bench for sbox_share_ctrl: randomized and directed requests checked
// against a table-based S-box model and the round-robin grant rule.
module tb_sbox_share_ctrl;
    localparam int NB      = 4;
    localparam int W       = 8 * NB;
    localparam bit RR_INIT = 1'b0;
`ifdef SBOX_SHARE_OUT_REG_EN
    localparam int LAT = NB + 2;
`else
    localparam int LAT = NB + 1;
`endif

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] state_dbg;

    sbox_share_ctrl_if #(.NBYTES(NB)) bus ();

    sbox_share_ctrl #(.NBYTES(NB), .RR_INIT(RR_INIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    logic [7:0] exp_t [0:255];
    logic [7:0] log_t [0:255];
    logic [7:0] fwd_t [0:255];
    logic [7:0] inv_t [0:255];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] a, input int n);
        return 8'((a << n) | (a >> (8 - n)));
    endfunction

    // Powers of generator 3 give log/antilog tables; inverse S-box is the reverse lookup.
    task automatic build_model();
        logic [7:0] e, b, s;
        e = 8'h01;
        for (int i = 0; i < 255; i++) begin
            exp_t[i] = e;
            log_t[e] = 8'(i);
            e = e ^ xt(e);
        end
        for (int x = 0; x < 256; x++) begin
            b = (x == 0) ? 8'h00 : exp_t[(255 - int'(log_t[x])) % 255];
            s = b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
            fwd_t[x] = s;
            inv_t[s] = 8'(x);
        end
    endtask

    function automatic logic [W-1:0] model_word(input logic [W-1:0] d, input logic inv);
        logic [W-1:0] r;
        for (int k = 0; k < NB; k++) r[8*k +: 8] = inv ? inv_t[d[8*k +: 8]] : fwd_t[d[8*k +: 8]];
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    int checks = 0;
    int fails  = 0;
    logic [W:0] exp_q[$];
    int         acc_q[$];
    logic       tb_busy    = 1'b0;
    logic       in_rsp     = 1'b0;
    logic       last_owner = ~RR_INIT;
    logic [W:0] held;
    int         ks_hs = 0;
    int         dp_hs = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        fails++;
        $display("FAIL %s: condition not met (cycle %0d)", name, cyc);
    endtask

    task automatic accept(input logic own, input logic [W-1:0] d, input logic inv);
        exp_q.push_back({own, model_word(d, inv)});
        acc_q.push_back(cyc);
        last_owner = own;
        tb_busy    = 1'b1;
        if (own) dp_hs++; else ks_hs++;
    endtask

    always @(negedge clk) begin
        logic g;
        logic [W:0] got;
        if (!rst_n) begin
            chk("reset_outputs",
                {bus.ks_ready, bus.dp_ready, bus.rsp_valid, bus.rsp_owner, busy, bus.rsp_data}, 64'd0);
            exp_q.delete();
            acc_q.delete();
            tb_busy    = 1'b0;
            in_rsp     = 1'b0;
            last_owner = ~RR_INIT;
        end else begin
            chk("busy", busy, tb_busy);
            if (tb_busy) begin
                chk("ready_while_busy", {bus.ks_ready, bus.dp_ready}, 2'b00);
            end else begin
                if (bus.ks_valid && bus.dp_valid) g = !last_owner;
                else                              g = bus.dp_valid;
                chk("grant", {bus.ks_ready, bus.dp_ready},
                    (bus.ks_valid || bus.dp_valid) ? (g ? 2'b01 : 2'b10) : 2'b00);
                if (bus.ks_valid && bus.ks_ready)      accept(1'b0, bus.ks_data, 1'b0);
                else if (bus.dp_valid && bus.dp_ready) accept(1'b1, bus.dp_data, bus.dp_inverse);
            end
            if (bus.rsp_valid) begin
                got = {bus.rsp_owner, bus.rsp_data};
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    if (!in_rsp) begin
                        chk("rsp_latency", cyc, acc_q[0] + LAT);
                        in_rsp = 1'b1;
                        held   = got;
                    end else begin
                        chk("rsp_stable", got, held);
                    end
                    if (bus.rsp_ready) begin
                        chk("rsp_word", got, exp_q.pop_front());
                        void'(acc_q.pop_front());
                        in_rsp  = 1'b0;
                        tb_busy = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ks_send(input logic [W-1:0] d);
        int n0;
        int budget;
        n0     = ks_hs;
        budget = 300;
        bus.ks_valid = 1'b1;
        bus.ks_data  = d;
        while (ks_hs == n0 && budget > 0) begin
            step();
            budget--;
        end
        if (ks_hs == n0) fail_now("ks_accept_timeout");
        bus.ks_valid = 1'b0;
    endtask

    task automatic dp_send(input logic [W-1:0] d, input logic inv);
        int n0;
        int budget;
        n0     = dp_hs;
        budget = 300;
        bus.dp_valid   = 1'b1;
        bus.dp_data    = d;
        bus.dp_inverse = inv;
        while (dp_hs == n0 && budget > 0) begin
            step();
            budget--;
        end
        if (dp_hs == n0) fail_now("dp_accept_timeout");
        bus.dp_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        b = 0;
        bus.rsp_ready = 1'b1;
        while (tb_busy && b < 100) begin
            step();
            b++;
        end
        if (tb_busy) fail_now("drain_timeout");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // ---------------- stimulus ----------------
    logic rand_on;

    initial begin
        build_model();
        rst_n          = 1'b1;
        bus.ks_valid   = 1'b0;
        bus.ks_data    = '0;
        bus.dp_valid   = 1'b0;
        bus.dp_data    = '0;
        bus.dp_inverse = 1'b0;
        bus.rsp_ready  = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Known-answer words in both directions.
        ks_send(32'h0000_0000);
        drain();
        dp_send(32'h7B77_7C63, 1'b1);
        drain();
        ks_send(32'h0302_0100);
        drain();

        // Both requesters always valid after reset: KS, DP, KS, DP.
        do_reset();
        fork
            begin ks_send(32'h0011_2233); ks_send(32'h4455_6677); end
            begin dp_send(32'h8899_AABB, 1'b0); dp_send(32'hCCDD_EEFF, 1'b1); end
        join
        drain();

        // Response back-pressure in DONE with a competing request waiting.
        bus.rsp_ready = 1'b0;
        ks_send(32'h1234_5678);
        fork
            dp_send(W'($urandom), 1'b0);
            begin repeat (NB + 12) step(); bus.rsp_ready = 1'b1; end
        join
        drain();

        // Reset while byte 2 is on the S-box; the word must vanish.
        ks_send(32'hDEAD_BEEF);
        step();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        ks_send(32'hCAFE_F00D);
        drain();

        // Randomized traffic with random response back-pressure.
        rand_on = 1'b1;
        fork
            begin
                fork
                    for (int i = 0; i < 30; i++) begin
                        repeat ($urandom_range(0, 3)) step();
                        ks_send(W'($urandom));
                    end
                    for (int j = 0; j < 30; j++) begin
                        repeat ($urandom_range(0, 3)) step();
                        dp_send(W'($urandom), 1'($urandom_range(0, 1)));
                    end
                join
                rand_on = 1'b0;
            end
            while (rand_on) begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
                step();
            end
        join
        drain();
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
